// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared FSM states, window geometry and sizing helpers for the
// 3x3 convolution frame sequencer.
package conv_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int WIN_ELEMS = 9;
  function automatic int n_out(input int w, input int h);
    return (h - 2) * (w - 2);
  endfunction
  function automatic int beat_w(input int dw);
    return 2 * WIN_ELEMS * dw;
  endfunction
endpackage

// File: rtl/conv_result_fifo.sv
// conv_result_fifo: synchronous first-word-fall-through FIFO with occupancy count;
// the head entry is visible on dout_o whenever valid_o is high.
module conv_result_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             push_i,
  input  logic [WIDTH-1:0]                 din_i,
  input  logic                             pop_i,
  output logic [WIDTH-1:0]                 dout_o,
  output logic                             valid_o,
  output logic [$clog2(DEPTH+1)-1:0]       count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_pop;
  assign valid_o = cnt_q != '0;
  assign do_pop = pop_i && valid_o;
  assign dout_o = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;
  always_ff @(posedge aclk)
    if (!aresetn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= (push_i && !do_pop) ? cnt_q + 1'b1 : (!push_i && do_pop) ? cnt_q - 1'b1 : cnt_q;
    end
  // Upstream credit accounting must make this unreachable.
  assert property (@(posedge aclk) disable iff (!aresetn) !(push_i && cnt_q == CW'(DEPTH)));
endmodule

// File: rtl/conv3x3_frame_sequencer.sv
// conv3x3_frame_sequencer: streams a raster frame through two line buffers, issues one
// patch+kernel beat per unpadded 3x3 window and collects engine results into an output FIFO.
module conv3x3_frame_sequencer
  import conv_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 20,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int ENGINE_LAT = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [WIN_ELEMS*DATA_WIDTH-1:0]   cfg_kernel,
  input  logic                              cfg_load,
  input  logic                              start,
  input  logic [DATA_WIDTH-1:0]             s_pix_tdata,
  input  logic                              s_pix_tvalid,
  output logic                              s_pix_tready,
  output logic [beat_w(DATA_WIDTH)-1:0]     eng_tdata,
  output logic                              eng_tvalid,
  input  logic [OUT_WIDTH-1:0]              eng_result,
  output logic [OUT_WIDTH-1:0]              m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              busy,
  output logic                              done
);
  localparam int NO = n_out(IMG_W, IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NW = $clog2(NO + 1);
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  state_t state_q, state_d;
  logic [WIN_ELEMS*DATA_WIDTH-1:0] kernel_q;
  logic [WIN_ELEMS-1:0][DATA_WIDTH-1:0] win_q, win_d;
  logic [IMG_W-1:0][DATA_WIDTH-1:0] lb0_q, lb1_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [NW-1:0] res_q;
  logic [ENGINE_LAT-1:0] infl_q;
  logic [FW-1:0] fifo_cnt;
  logic acc, issue, col_end, last_pix, push, drained;
  assign col_end = col_q == CW'(IMG_W - 1);
  // Every issued-but-unpopped result owns a FIFO slot, so the engine can never overrun it.
  assign s_pix_tready = state_q == RUN && int'(fifo_cnt) + $countones(infl_q) < FIFO_DEPTH;
  assign acc = s_pix_tvalid && s_pix_tready;
  assign issue = acc && row_q >= RW'(2) && col_q >= CW'(2);
  assign last_pix = acc && col_end && row_q == RW'(IMG_H - 1);
  assign push = infl_q[ENGINE_LAT-1];
  assign drained = infl_q == '0 && fifo_cnt == '0;
  // New column enters on the right: two rows back, one row back, current pixel.
  assign win_d = {s_pix_tdata, win_q[8:7], lb0_q[IMG_W-1], win_q[5:4], lb1_q[IMG_W-1], win_q[2:1]};
  assign eng_tdata = {kernel_q, win_q};
  assign eng_tvalid = infl_q[0];
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (last_pix) state_d = DRAIN;
      DRAIN: if (drained) state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk)
    if (!aresetn) begin
      state_q <= IDLE;
      kernel_q <= '0;
      win_q <= '0;
      lb0_q <= '0;
      lb1_q <= '0;
      col_q <= '0;
      row_q <= '0;
      res_q <= '0;
      infl_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cfg_load) kernel_q <= cfg_kernel;
      if (state_q == IDLE && start) begin
        col_q <= '0;
        row_q <= '0;
        res_q <= '0;
      end else if (acc) begin
        col_q <= col_end ? '0 : col_q + 1'b1;
        if (col_end) row_q <= row_q + 1'b1;
      end
      if (acc) begin
        win_q <= win_d;
        lb0_q <= {lb0_q[IMG_W-2:0], s_pix_tdata};
        lb1_q <= {lb1_q[IMG_W-2:0], lb0_q[IMG_W-1]};
      end
      infl_q <= ENGINE_LAT'({infl_q, issue});
      if (push) res_q <= res_q + 1'b1;
    end
  conv_result_fifo #(.WIDTH(OUT_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push_i  (push),
    .din_i   ({res_q == NW'(NO - 1), eng_result}),
    .pop_i   (m_axis_tready),
    .dout_o  ({m_axis_tlast, m_axis_tdata}),
    .valid_o (m_axis_tvalid),
    .count_o (fifo_cnt)
  );
endmodule

// File: tb/tb_conv3x3_frame_sequencer.sv
// tb_conv3x3_frame_sequencer: directed frames against a behavioural 3x3 MAC engine,
// checking results, tlast, done/busy, credit-limited backpressure and mid-frame reset.
module tb_conv3x3_frame_sequencer;
  localparam int DW = 8;
  localparam int OW = 20;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [9*DW-1:0] cfg_kernel = '0;
  logic cfg_load = 1'b0, start = 1'b0;
  logic [DW-1:0] s_pix_tdata = '0;
  logic s_pix_tvalid = 1'b0, s_pix_tready;
  logic [18*DW-1:0] eng_tdata;
  logic eng_tvalid;
  logic [OW-1:0] eng_result;
  logic [OW-1:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, busy, done;
  logic m_axis_tready = 1'b1;
  int n_cmp = 0, n_err = 0, issue_cnt = 0, done_cnt = 0, pi = 0;
  logic [OW-1:0] got_d[$];
  logic got_l[$];
  logic [OW-1:0] p1 = '0, p2 = '0, p3 = '0;
  localparam logic [9*DW-1:0] K_ONES = {9{8'd1}};
  localparam logic [9*DW-1:0] K_CTR = 72'd1 << 32;
  localparam logic [9*DW-1:0] K_FF = {9{8'hFF}};

  always #5 aclk = ~aclk;

  conv3x3_frame_sequencer dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_kernel(cfg_kernel), .cfg_load(cfg_load), .start(start),
    .s_pix_tdata(s_pix_tdata), .s_pix_tvalid(s_pix_tvalid), .s_pix_tready(s_pix_tready),
    .eng_tdata(eng_tdata), .eng_tvalid(eng_tvalid), .eng_result(eng_result),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done)
  );

  function automatic logic [OW-1:0] eng_f(input logic [18*DW-1:0] b);
    logic [OW-1:0] s = '0;
    for (int i = 0; i < 9; i++) s += OW'(b[(9+i)*DW +: DW]) * OW'(b[i*DW +: DW]);
    return s;
  endfunction

  // Engine model: result of the beat present after the issue edge is readable 4 edges later.
  always @(posedge aclk) begin
    p1 <= eng_f(eng_tdata);
    p2 <= p1;
    p3 <= p2;
  end
  assign eng_result = p3;

  always @(posedge aclk)
    if (aresetn) begin
      if (eng_tvalid) issue_cnt++;
      if (done) done_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        got_d.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
      end
    end

  function automatic logic [DW-1:0] pix(input int mode, input int i);
    return mode == 0 ? 8'd1 : mode == 1 ? DW'(i) : 8'hFF;
  endfunction

  function automatic logic [63:0] exp_res(input int t, input int k);
    int b = 8 * (k / 6) + k % 6;
    return 64'(t == 0 ? 9 : t == 1 ? b + 9 : t == 2 ? 585225 : t == 3 ? 255 * (9 * b + 81) : 9 * b + 81);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic feed(input int mode, input int upto, input int budget);
    logic rdy;
    for (int n = 0; n < budget && pi < upto; n++) begin
      s_pix_tvalid = 1'b1;
      s_pix_tdata = pix(mode, pi);
      rdy = s_pix_tready;
      tick();
      if (rdy) pi++;
    end
    s_pix_tvalid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int prev);
    for (int n = 0; n < 400 && done_cnt == prev; n++) tick();
    repeat (3) tick();
    check({tag, "_done_pulses"}, 64'(done_cnt - prev), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic check_frame(input string tag, input int t, input int b, input int ib);
    check({tag, "_count"}, 64'(got_d.size() - b), 64'd36);
    check({tag, "_issues"}, 64'(issue_cnt - ib), 64'd36);
    for (int k = 0; k < 36 && b + k < got_d.size(); k++) begin
      check($sformatf("%s_data%0d", tag, k), 64'(got_d[b+k]), exp_res(t, k));
      check($sformatf("%s_last%0d", tag, k), 64'(got_l[b+k]), 64'(k == 35));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tready"}, 64'(s_pix_tready), 64'd0);
    check({tag, "_eng_tvalid"}, 64'(eng_tvalid), 64'd0);
    check({tag, "_eng_tdata_zero"}, 64'(eng_tdata == '0), 64'd1);
    check({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check({tag, "_m_tdata"}, 64'(m_axis_tdata), 64'd0);
    check({tag, "_m_tlast"}, 64'(m_axis_tlast), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic load_start(input logic [9*DW-1:0] k, input logic ld, input logic st);
    cfg_kernel = k;
    cfg_load = ld;
    start = st;
    tick();
    cfg_load = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int b, ib, dp;
    // Reset with load/start asserted: nothing may latch.
    cfg_kernel = K_ONES;
    cfg_load = 1'b1;
    start = 1'b1;
    repeat (2) tick();
    check_idle_outputs("reset");
    cfg_load = 1'b0;
    start = 1'b0;
    aresetn = 1'b1;
    tick();
    // Frame 1: all-ones kernel, flat image.
    load_start(K_ONES, 1'b1, 1'b0);
    check("idle_after_load_busy", 64'(busy), 64'd0);
    b = got_d.size(); ib = issue_cnt; dp = done_cnt;
    load_start(K_ONES, 1'b0, 1'b1);
    check("run_busy", 64'(busy), 64'd1);
    pi = 0;
    feed(0, 64, 2000);
    check("f1_pixels", 64'(pi), 64'd64);
    wait_done("f1", dp);
    check_frame("f1", 0, b, ib);
    // Frame 2: load+start together with centre kernel; load/start during RUN ignored.
    b = got_d.size(); ib = issue_cnt; dp = done_cnt;
    load_start(K_CTR, 1'b1, 1'b1);
    pi = 0;
    feed(1, 10, 200);
    cfg_kernel = K_FF;
    cfg_load = 1'b1;
    start = 1'b1;
    feed(1, 30, 200);
    cfg_load = 1'b0;
    start = 1'b0;
    feed(1, 64, 2000);
    wait_done("f2", dp);
    check_frame("f2", 1, b, ib);
    // Frame 3: saturating-size inputs, no wrap expected.
    b = got_d.size(); ib = issue_cnt; dp = done_cnt;
    load_start(K_FF, 1'b1, 1'b1);
    pi = 0;
    feed(2, 64, 2000);
    wait_done("f3", dp);
    check_frame("f3", 2, b, ib);
    // Frame 4: output stalled from start, kernel kept from frame 3.
    b = got_d.size(); ib = issue_cnt; dp = done_cnt;
    m_axis_tready = 1'b0;
    load_start('0, 1'b0, 1'b1);
    pi = 0;
    feed(1, 64, 150);
    check("bp_pixels_accepted", 64'(pi), 64'd22);
    check("bp_issues", 64'(issue_cnt - ib), 64'd4);
    check("bp_tready_low", 64'(s_pix_tready), 64'd0);
    check("bp_m_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("bp_head", 64'(m_axis_tdata), 64'd20655);
    repeat (3) tick();
    check("bp_head_stable", 64'(m_axis_tdata), 64'd20655);
    check("bp_none_delivered", 64'(got_d.size() - b), 64'd0);
    m_axis_tready = 1'b1;
    feed(1, 64, 2000);
    wait_done("bp", dp);
    check_frame("bp", 3, b, ib);
    // Frame 5: reset after 20 pixels, then a clean frame with a fresh kernel.
    load_start('0, 1'b0, 1'b1);
    pi = 0;
    feed(1, 20, 200);
    aresetn = 1'b0;
    tick();
    check_idle_outputs("midrst");
    aresetn = 1'b1;
    b = got_d.size();
    repeat (10) tick();
    check("midrst_no_stale_valid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_no_stale_out", 64'(got_d.size() - b), 64'd0);
    ib = issue_cnt; dp = done_cnt;
    load_start(K_ONES, 1'b1, 1'b1);
    pi = 0;
    feed(1, 64, 2000);
    wait_done("f5", dp);
    check_frame("f5", 4, b, ib);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/conv3x3_frame_sequencer.md
Name: conv3x3_frame_sequencer

Overview:
Frame-level controller for the 3x3 convolution MAC engine (18-byte AXI4-Stream patch+kernel in, 20-bit result out, fixed 4-cycle latency, no valid tracking, always ready). It accepts a raster pixel stream and holds a loaded 3x3 kernel. It builds sliding windows with two line buffers and issues one patch+kernel beat per valid (unpadded) output position. It tracks in-flight engine results by latency and buffers them into a backpressure-safe output stream with tlast.

Parameters:
DATA_WIDTH, 8, pixel/kernel element width
OUT_WIDTH, 20, engine result width
IMG_W, 8, frame width in pixels (>=3)
IMG_H, 8, frame height in pixels (>=3)
ENGINE_LAT, 4, clock edges from issue edge to the edge where eng_result holds that beat's result
FIFO_DEPTH, 4, output result FIFO entries (power of 2, >= 2)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
cfg_kernel  in  9*DATA_WIDTH  kernel; element i at [i*DATA_WIDTH +: DATA_WIDTH], row-major
cfg_load  in  1  latch cfg_kernel (honoured in IDLE only)
start  in  1  begin frame (honoured in IDLE only)
s_pix_tdata  in  DATA_WIDTH  raster-order pixel
s_pix_tvalid  in  1  pixel valid
s_pix_tready  out  1  pixel accepted when valid&&ready
eng_tdata  out  18*DATA_WIDTH  {kernel[8..0], window[8..0]}; window in low 9*DATA_WIDTH bits
eng_tvalid  out  1  issue strobe to engine
eng_result  in  OUT_WIDTH  engine result (engine m_axis_tdata)
m_axis_tdata  out  OUT_WIDTH  convolution result
m_axis_tvalid  out  1  result valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last result of frame
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (aresetn=0 at posedge): state=IDLE, kernel reg=0, counters/line buffers cleared, in-flight shift reg=0, FIFO empty. All outputs 0.
- States: IDLE -> RUN on start; RUN -> DRAIN on the edge accepting pixel IMG_W*IMG_H; DRAIN -> DONE when in-flight=0 and FIFO empty; DONE -> IDLE unconditionally (done=1 for that one cycle).
- IDLE: cfg_load latches kernel. If start and cfg_load coincide, the kernel latches and RUN begins with the new kernel. Entering RUN clears row/col/result counters. start/cfg_load ignored in RUN/DRAIN/DONE.
- Pixel path: col/row counters wrap col at IMG_W-1, increment row. Each accepted pixel shifts into the 3x3 window (3 columns from line buffer 1, line buffer 0, new pixel). window[0] = top-left (row r-2, col c-2), window[8] = current pixel.
- Issue: on the accepting edge with row>=2 and col>=2, register eng_tdata and assert eng_tvalid for exactly the next cycle; otherwise eng_tvalid=0. There are (IMG_H-2)*(IMG_W-2) issues per frame (36 at default).
- Latency tracking: ENGINE_LAT-bit shift register. Bit 0 loads issue flag; the MSB set means push eng_result into FIFO on that edge. The engine ignores eng_tready; the sequencer never issues without a guaranteed slot.
- Credit rule: s_pix_tready = (state==RUN) && (fifo_count + inflight_count + pending_issue < FIFO_DEPTH). This holds regardless of whether the pixel completes a window (conservative). A simultaneous FIFO pop in the same cycle is not counted as credit.
- Output: standard first-word-fall-through FIFO. Pop when m_axis_tvalid && m_axis_tready. tlast is stored per entry, set on result index (IMG_H-2)*(IMG_W-2)-1. Data is held stable while tvalid && !tready.
- Push and pop in the same cycle: count unchanged. A push into a full FIFO is impossible by the credit rule; an assertion flags it.
- Reset mid-frame: everything returns to reset values next edge. In-flight engine results are discarded, and the engine's stale output is ignored because the shift register is cleared.
- Widths: counters are $clog2 of their ranges; no arithmetic on results (saturation is the engine's job).

Decomposition:
- Package conv_seq_pkg: state enum {IDLE,RUN,DRAIN,DONE}, localparams WIN_ELEMS=9, N_OUT=(IMG_H-2)*(IMG_W-2) helper function, beat width 18*DATA_WIDTH.
- Sub-module: conv_result_fifo (sync FWFT FIFO, width OUT_WIDTH+1, depth FIFO_DEPTH, count output). Line buffers stay inline.

Test Plan:
- Kernel all 1, 8x8 frame of pixel 1, tready=1 -> 36 results all 9, tlast only on 36th, done pulse once, busy low after.
- Kernel center=1 else 0, pixel = row*8+col -> results 9,10..14,17..22,...,49..54 in raster order (result(r,c)=8(r+1)+c+1).
- Kernel all 255, pixels all 255 -> every result 585225 (0x8EE09), no wrap.
- m_axis_tready=0 from start -> exactly FIFO_DEPTH results buffered, s_pix_tready drops, no issue beyond credit. Release tready -> all 36 results delivered in order, none lost/duplicated.
- aresetn low for 1 cycle after 20 pixels -> all outputs 0. New start with a full frame yields exactly 36 correct results with no stale outputs.
- cfg_load with new kernel during RUN -> ignored, frame uses old kernel. start during RUN ignored. Kernel changes only when loaded in IDLE.
